// File: rtl/ber_sci_disp.sv
// Bit-error-rate formatter: turns a received-bit count R and an error count E into
// a truncated d1.d2..dN x 10^-EXP result, with BCD digits and 7-segment codes.
module ber_sci_disp #(
  parameter int BW_RECV = 58,
  parameter int BW_ERR  = 64,
  parameter int NMANT   = 3,
  parameter int EXP_MAX = 19
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [BW_RECV-1:0]   RECV_CNT,
  input  logic [BW_ERR-1:0]    ERR_CNT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [4*NMANT-1:0]   MANT_BCD,
  output logic [7:0]           EXP_BCD,
  output logic                 NO_DATA,
  output logic                 ZERO,
  output logic                 OVER,
  output logic                 UNDER,
  output logic [7*NMANT-1:0]   SEG_MANT,
  output logic [13:0]          SEG_EXP
);

  localparam int BW_Q = 4 * NMANT;
  localparam int BW_N = (BW_ERR > BW_RECV + BW_Q) ? BW_ERR : BW_RECV + BW_Q;
  localparam int BW_C = 5;
  localparam logic [BW_C-1:0] FRAC_LAST   = BW_C'((NMANT > 1) ? NMANT - 2 : 0);
  localparam logic [BW_C-1:0] QBIT_LAST   = BW_C'(BW_Q - 1);
  localparam logic [7:0]      EXP_MAX_BCD = {4'(EXP_MAX / 10), 4'(EXP_MAX % 10)};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SCALE = 3'd2,
    S_FRAC  = 3'd3,
    S_DIV   = 3'd4,
    S_BCD   = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    K_NORMAL = 3'd0,
    K_NODATA = 3'd1,
    K_ZERO   = 3'd2,
    K_OVER   = 3'd3,
    K_UNDER  = 3'd4
  } kind_e;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] o;
    if (v[3:0] == 4'd9) begin
      o = {v[7:4] + 4'd1, 4'd0};
    end else begin
      o = {v[7:4], v[3:0] + 4'd1};
    end
    return o;
  endfunction

  // Double-dabble correction: every digit of 5 or more gets +3 before the shift.
  function automatic logic [BW_Q-1:0] dabble_adj(input logic [BW_Q-1:0] v);
    logic [BW_Q-1:0] o;
    o = v;
    for (int i = 0; i < NMANT; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        o[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end else begin
        o[4*i +: 4] = v[4*i +: 4];
      end
    end
    return o;
  endfunction

  state_e              state_q, state_d;
  kind_e               done_kind;
  logic [BW_RECV-1:0]  r_q, r_d;
  logic [BW_N-1:0]     n_q, n_d;
  logic [BW_N-1:0]     r_ext;
  logic [BW_N-1:0]     n_times10;
  logic [7:0]          k_q, k_d;
  logic [BW_C-1:0]     cnt_q, cnt_d;
  logic [BW_RECV-1:0]  rem_q, rem_d;
  logic [BW_Q-1:0]     qsh_q, qsh_d;
  logic [BW_Q-1:0]     bcd_q, bcd_d;
  logic [BW_RECV:0]    trial;
  logic [BW_RECV-1:0]  diff;
  logic                trial_ge;
  logic [BW_Q-1:0]     adj;

  logic [BW_Q-1:0]     mant_q, mant_d;
  logic [7:0]          exp_q, exp_d;
  logic                nodata_q, nodata_d;
  logic                zero_q, zero_d;
  logic                over_q, over_d;
  logic                under_q, under_d;
  logic [7*NMANT-1:0]  seg_mant_q, seg_mant_d;
  logic [13:0]         seg_exp_q, seg_exp_d;

  assign r_ext     = BW_N'(r_q);
  assign n_times10 = (n_q << 3) + (n_q << 1);
  assign trial     = {rem_q, qsh_q[BW_Q-1]};
  assign trial_ge  = (trial >= {1'b0, r_q});
  assign diff      = trial[BW_RECV-1:0] - r_q;
  assign adj       = dabble_adj(bcd_q);

  // State register; reset beats a coincident START.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and classification of the result that DONE will carry.
  always_comb begin
    state_d   = state_q;
    done_kind = K_NORMAL;
    if (START) begin
      state_d = S_CHECK;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_CHECK: begin
          if (r_q == '0) begin
            state_d   = S_DONE;
            done_kind = K_NODATA;
          end else if (n_q == '0) begin
            state_d   = S_DONE;
            done_kind = K_ZERO;
          end else if (n_q > r_ext) begin
            state_d   = S_DONE;
            done_kind = K_OVER;
          end else begin
            state_d = S_SCALE;
          end
        end
        S_SCALE: begin
          if (n_q >= r_ext) begin
            state_d = (NMANT == 1) ? S_DIV : S_FRAC;
          end else if (k_q == EXP_MAX_BCD) begin
            state_d   = S_DONE;
            done_kind = K_UNDER;
          end else begin
            state_d = S_SCALE;
          end
        end
        S_FRAC: state_d = (cnt_q == FRAC_LAST) ? S_DIV : S_FRAC;
        S_DIV:  state_d = (cnt_q == QBIT_LAST) ? S_BCD : S_DIV;
        S_BCD:  state_d = (cnt_q == QBIT_LAST) ? S_DONE : S_BCD;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: scaling by ten, restoring divide and BCD conversion.
  always_comb begin
    r_d   = r_q;
    n_d   = n_q;
    k_d   = k_q;
    rem_d = rem_q;
    qsh_d = qsh_q;
    bcd_d = bcd_q;
    if (START) begin
      r_d = RECV_CNT;
      n_d = BW_N'(ERR_CNT);
      k_d = 8'h00;
    end else begin
      case (state_q)
        S_SCALE: begin
          if ((n_q < r_ext) && (k_q != EXP_MAX_BCD)) begin
            n_d = n_times10;
            k_d = bcd_inc(k_q);
          end else begin
            n_d = n_q;
          end
        end
        S_FRAC: n_d = n_times10;
        S_DIV: begin
          if (trial_ge) begin
            rem_d = diff;
            qsh_d = (qsh_q << 1) | BW_Q'(1);
          end else begin
            rem_d = trial[BW_RECV-1:0];
            qsh_d = qsh_q << 1;
          end
        end
        S_BCD: begin
          bcd_d = (adj << 1) | BW_Q'(qsh_q[BW_Q-1]);
          qsh_d = qsh_q << 1;
        end
        default: n_d = n_q;
      endcase
    end
    // Quotient fits BW_Q bits, so everything above the low BW_Q bits of N is below R.
    if ((state_d == S_DIV) && (state_q != S_DIV)) begin
      rem_d = n_d[BW_Q +: BW_RECV];
      qsh_d = n_d[BW_Q-1:0];
    end else begin
      rem_d = rem_d;
    end
    if ((state_d == S_BCD) && (state_q != S_BCD)) begin
      bcd_d = '0;
    end else begin
      bcd_d = bcd_d;
    end
    cnt_d = (state_d != state_q) ? 5'd0 : cnt_q + 5'd1;
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q   <= '0;
      n_q   <= '0;
      k_q   <= 8'h00;
      cnt_q <= 5'd0;
      rem_q <= '0;
      qsh_q <= '0;
      bcd_q <= '0;
    end else begin
      r_q   <= r_d;
      n_q   <= n_d;
      k_q   <= k_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      qsh_q <= qsh_d;
      bcd_q <= bcd_d;
    end
  end

  // Result values, loaded only on the edge that enters DONE.
  always_comb begin
    mant_d     = mant_q;
    exp_d      = exp_q;
    nodata_d   = nodata_q;
    zero_d     = zero_q;
    over_d     = over_q;
    under_d    = under_q;
    seg_mant_d = seg_mant_q;
    seg_exp_d  = seg_exp_q;
    if (state_d == S_DONE) begin
      mant_d   = '0;
      exp_d    = 8'h00;
      nodata_d = 1'b0;
      zero_d   = 1'b0;
      over_d   = 1'b0;
      under_d  = 1'b0;
      case (done_kind)
        K_NORMAL: begin
          mant_d = bcd_d;
          exp_d  = k_q;
        end
        K_NODATA: nodata_d = 1'b1;
        K_ZERO:   zero_d   = 1'b1;
        K_OVER:   over_d   = 1'b1;
        K_UNDER: begin
          under_d = 1'b1;
          exp_d   = EXP_MAX_BCD;
        end
        default: mant_d = '0;
      endcase
      for (int i = 0; i < NMANT; i++) begin
        seg_mant_d[7*i +: 7] = seg7(mant_d[4*i +: 4]);
      end
      seg_exp_d = {seg7(exp_d[7:4]), seg7(exp_d[3:0])};
      if (nodata_d) begin
        seg_mant_d = '0;
        seg_exp_d  = 14'h0000;
      end else if (over_d) begin
        seg_mant_d = {NMANT{7'h40}};
        seg_exp_d  = {2{7'h40}};
      end else if (under_d) begin
        seg_mant_d = {NMANT{7'h40}};
      end else begin
        seg_exp_d = seg_exp_d;
      end
    end else begin
      mant_d = mant_q;
    end
  end

  // Result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mant_q     <= '0;
      exp_q      <= 8'h00;
      nodata_q   <= 1'b0;
      zero_q     <= 1'b0;
      over_q     <= 1'b0;
      under_q    <= 1'b0;
      seg_mant_q <= '0;
      seg_exp_q  <= 14'h0000;
    end else begin
      mant_q     <= mant_d;
      exp_q      <= exp_d;
      nodata_q   <= nodata_d;
      zero_q     <= zero_d;
      over_q     <= over_d;
      under_q    <= under_d;
      seg_mant_q <= seg_mant_d;
      seg_exp_q  <= seg_exp_d;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    BUSY = (state_q != S_IDLE);
    DONE = (state_q == S_DONE);
  end

  assign MANT_BCD = mant_q;
  assign EXP_BCD  = exp_q;
  assign NO_DATA  = nodata_q;
  assign ZERO     = zero_q;
  assign OVER     = over_q;
  assign UNDER    = under_q;
  assign SEG_MANT = seg_mant_q;
  assign SEG_EXP  = seg_exp_q;

endmodule

// File: doc/ber_sci_disp.md
BER_SCI_DISP -- requirements
Module: ber_sci_disp

Interface
REQ-001 Parameter BW_RECV, default 58: width of RECV_CNT.
REQ-002 Parameter BW_ERR, default 64: width of ERR_CNT.
REQ-003 Parameter NMANT, default 3, legal range 1..4: number of mantissa digits; BW_Q = 4*NMANT.
REQ-004 Parameter EXP_MAX, default 19, legal range 1..99: largest displayable exponent.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 CLK  in  1  rising-edge clock.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 START  in  1  one-cycle request; captures RECV_CNT/ERR_CNT at the same edge.
REQ-009 RECV_CNT  in  BW_RECV  received-bit count R.
REQ-010 ERR_CNT  in  BW_ERR  error count E.
REQ-011 BUSY  out  1  high whenever state != IDLE.
REQ-012 DONE  out  1  one-cycle pulse; result outputs are valid in the same cycle.
REQ-013 MANT_BCD  out  4*NMANT  mantissa digits, most significant digit in the top nibble.
REQ-014 EXP_BCD  out  8  exponent as two BCD digits.
REQ-015 NO_DATA, ZERO, OVER, UNDER  out  1 each  result status flags.
REQ-016 SEG_MANT  out  7*NMANT; SEG_EXP  out  14: active-high 7-segment codes, bit i = segment a+i, one 7-bit field per digit.

Function
REQ-017 Result meaning: BER = d1.d2..dN x 10^-EXP, truncated, not rounded.
REQ-018 States: IDLE, CHECK, SCALE, FRAC, DIV, BCD, DONE.
REQ-019 IDLE: START -> CHECK; capture R <- RECV_CNT and N <- ERR_CNT (N zero-extended to BW_N = max(BW_ERR, BW_RECV+4*NMANT)); clear k.
REQ-020 CHECK, first match wins: R==0 -> DONE with NO_DATA; E==0 -> DONE with ZERO; E>R -> DONE with OVER; otherwise -> SCALE.
REQ-021 SCALE, one step per cycle: N>=R -> FRAC (or DIV if NMANT==1); else k==EXP_MAX -> DONE with UNDER; else N <- 10N and k <- k+1.
REQ-022 The exponent k SHALL be held directly as a 2-digit BCD counter; no binary-to-BCD step is used for the exponent.
REQ-023 FRAC: NMANT-1 cycles, N <- 10N each cycle.
REQ-024 DIV: restoring division Q = floor(N/R), one quotient bit per cycle, MSB first, BW_Q cycles.
REQ-025 BCD: double-dabble conversion of Q, one bit per cycle, BW_Q cycles.
REQ-026 For normal results, 10^(NMANT-1) <= Q <= 10^NMANT - 1.
REQ-027 Multiply by 10 SHALL be (N<<3)+(N<<1), single cycle, with no overflow within BW_N.
REQ-028 Normal-path latency: START in cycle 0 gives DONE in cycle k+NMANT+2+2*BW_Q.
REQ-029 Special-path latency: NO_DATA, ZERO and OVER give DONE in cycle 2; UNDER gives DONE in cycle EXP_MAX+3.
REQ-030 DONE state lasts one cycle, then -> IDLE.
REQ-031 Result registers (MANT_BCD, EXP_BCD, flags, SEG_*) SHALL load only at the edge entering DONE and hold until the next load.
REQ-032 Exactly one flag SHALL be set per result; all four flags are 0 for a normal result.
REQ-033 Result values by case:
  - ZERO: mantissa 0, EXP 00.
  - OVER: mantissa 0, EXP 00.
  - UNDER: mantissa 0, EXP = EXP_MAX.
  - NO_DATA: mantissa 0, EXP 00.
REQ-034 Segment values by case:
  - NO_DATA: all segment fields 7'h00 (blank).
  - OVER: all fields 7'h40 (dash).
  - UNDER: mantissa fields 7'h40, exponent fields show EXP_MAX.
  - otherwise: digits 0-9 in standard form.
REQ-035 START in any non-IDLE state SHALL abort the current computation, recapture the inputs and go to CHECK; no DONE is issued for the aborted run.

Reset
REQ-036 RST SHALL force IDLE, BUSY=0, DONE=0, all result outputs 0, all flags 0 and SEG_* = 7'h00 per digit, taking priority over START in the same cycle.
REQ-037 RST mid-computation SHALL discard the run; no DONE follows.

Verification (NMANT=3, EXP_MAX=19 unless stated)
REQ-038 R=1000, E=3, START -> DONE in cycle 32, MANT_BCD=12'h300, EXP_BCD=8'h03, flags 0.
REQ-039 R=7, E=2 -> MANT_BCD=12'h285, EXP_BCD=8'h01, DONE in cycle 30.
REQ-040 R=0 -> DONE in cycle 2, NO_DATA=1, SEG all 0; then E=0, R=9 -> ZERO=1, MANT 000, EXP 00; then E=5, R=4 -> OVER=1, SEG all 7'h40.
REQ-041 EXP_MAX=5, R=1000001, E=1 -> DONE in cycle 8, UNDER=1, EXP_BCD=8'h05.
REQ-042 Restart: START (R=1000, E=3), second START in cycle 10 with R=7, E=2 -> exactly one DONE, in cycle 40, with result 285 / 01; outputs keep prior values until then.
REQ-043 Reset: RST asserted in cycle 15 of a run -> next cycle BUSY=0, outputs 0, no DONE; RST and START in the same cycle -> stays IDLE.
